// File: rtl/siso_shift_ctrl.sv
// Sequencer for a DEPTH-stage serial-in/serial-out shift register chain:
// serializes a parallel word into the chain head, flushes it, and reassembles the tail bits.
module siso_shift_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_d,
  output logic             sr_en,
  input  logic             sr_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_D    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_next;
  logic             tx_bit;

  // Whole-vector shifts keep WIDTH=1 legal where a part-select would go out of range.
  always_comb begin
    tx_bit  = 1'b0;
    tx_next = '0;
    rx_next = '0;
    if (LSB_FIRST) begin
      tx_bit  = tx[0];
      tx_next = tx >> 1;
      rx_next = (rx >> 1) | (WIDTH'(sr_q) << (WIDTH - 1));
    end else begin
      tx_bit  = tx[WIDTH-1];
      tx_next = tx << 1;
      rx_next = (rx << 1) | WIDTH'(sr_q);
    end
  end

  assign in_ready  = (state == IDLE);
  assign sr_en     = (state == SHIFT);
  assign sr_d      = (state == SHIFT) && (cnt < CNT_W) && tx_bit;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_data  = rx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      tx    <= '0;
      rx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tx    <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          tx  <= tx_next;
          cnt <= cnt + CW'(1);
          // The first DEPTH tail bits are stale chain contents and are discarded.
          if (cnt >= CNT_D) rx <= rx_next;
          if (cnt == CNT_LAST) state <= HOLD;
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
